// File: rtl/bcd_to_bin_pkg.sv
// Shared constants and FSM encoding for the packed-BCD to binary converter.
// Imported by the digit-adjust cell and the top level.
package bcd_to_bin_pkg;

  localparam int DIGIT_W    = 4;
  localparam int MAX_DIGIT  = 9;
  localparam int ADJ_THRESH = 8;
  localparam int ADJ_VAL    = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/bcd_to_bin_if.sv
// Start/finish handshake bundle for bcd_to_bin: the requester drives en and the
// operand, and the converter answers with the result, rdy and err.
interface bcd_to_bin_if #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
);
  logic                en;
  logic [4*DIGITS-1:0] bcd_d_in;
  logic [BIN_W-1:0]    bin_d_out;
  logic                rdy;
  logic                err;

  modport master (output en, bcd_d_in, input bin_d_out, rdy, err);
  modport slave  (input en, bcd_d_in, output bin_d_out, rdy, err);
endinterface

// File: rtl/bcd_to_bin_digit_adj.sv
// One BCD digit correction step of reverse double-dabble: a digit that reaches
// 8 after the right shift had a carry-in of 10 (seen as 8) and is reduced by 3.
module bcd_digit_adj
  import bcd_to_bin_pkg::*;
(
  input  logic [DIGIT_W-1:0] d_in,
  output logic [DIGIT_W-1:0] d_out
);

  assign d_out = (d_in >= DIGIT_W'(ADJ_THRESH)) ? d_in - DIGIT_W'(ADJ_VAL) : d_in;

endmodule

// File: rtl/bcd_to_bin.sv
// Sequential packed-BCD to binary converter (reverse double-dabble, one bit per
// cycle) with an en/rdy start/finish handshake and an illegal-digit flag.
module bcd_to_bin
  import bcd_to_bin_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input  logic          clk,
  input  logic          rst,
  bcd_to_bin_if.slave   bus
);

  localparam int BCD_W = DIGIT_W * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

  state_e             state_q, state_d;
  logic [BCD_W-1:0]   bcd_sr_q, bcd_sr_d;
  logic [BIN_W-1:0]   bin_sr_q, bin_sr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               bad_q, bad_d;
  logic [BIN_W-1:0]   bin_out_q, bin_out_d;
  logic               rdy_q, rdy_d;
  logic               err_q, err_d;

  logic [BCD_W+BIN_W-1:0] shifted;
  logic [BCD_W-1:0]       bcd_shift;
  logic [BCD_W-1:0]       bcd_adj;
  logic                   bad_in;

  // The BCD LSB falls into the binary MSB; the binary result fills from the top.
  assign shifted   = {bcd_sr_q, bin_sr_q} >> 1;
  assign bcd_shift = shifted[BCD_W+BIN_W-1:BIN_W];

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .d_in  (bcd_shift[g*DIGIT_W +: DIGIT_W]),
      .d_out (bcd_adj[g*DIGIT_W +: DIGIT_W])
    );
  end

  always_comb begin
    bad_in = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bus.bcd_d_in[i*DIGIT_W +: DIGIT_W] > DIGIT_W'(MAX_DIGIT)) bad_in = 1'b1;
    end
  end

  always_comb begin
    // NOTE: every next-state signal defaults to its current value first, so no
    // path through the case leaves one unassigned and no latch is inferred.
    state_d   = state_q;
    bcd_sr_d  = bcd_sr_q;
    bin_sr_d  = bin_sr_q;
    cnt_d     = cnt_q;
    bad_d     = bad_q;
    bin_out_d = bin_out_q;
    rdy_d     = rdy_q;
    err_d     = err_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.en) begin
          bcd_sr_d = bus.bcd_d_in;
          bin_sr_d = '0;
          cnt_d    = '0;
          rdy_d    = 1'b0;
          err_d    = 1'b0;
          bad_d    = bad_in;
          state_d  = bad_in ? ST_DONE : ST_CONV;
        end
      end
      ST_CONV: begin
        bcd_sr_d = bcd_adj;
        bin_sr_d = shifted[BIN_W-1:0];
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) state_d = ST_DONE;
      end
      ST_DONE: begin
        bin_out_d = bad_q ? '0 : bin_sr_q;
        err_d     = bad_q;
        rdy_d     = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every flop samples the values
  // from before this edge, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      bcd_sr_q  <= '0;
      bin_sr_q  <= '0;
      cnt_q     <= '0;
      bad_q     <= 1'b0;
      bin_out_q <= '0;
      rdy_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bcd_sr_q  <= bcd_sr_d;
      bin_sr_q  <= bin_sr_d;
      cnt_q     <= cnt_d;
      bad_q     <= bad_d;
      bin_out_q <= bin_out_d;
      rdy_q     <= rdy_d;
      err_q     <= err_d;
    end
  end

  assign bus.bin_d_out = bin_out_q;
  assign bus.rdy       = rdy_q;
  assign bus.err       = err_q;

endmodule
